// File: rtl/condicionador_entradas.sv
// Input conditioning for the lighting controller. It synchronises the button and IR pins,
// turns button presses into debounced short/long events, and detects the IR rising edge.
module condicionador_entradas #(
  parameter int DEBOUNCE_P        = 300,
  parameter int SWITCH_MODE_MIN_T = 5000,
  parameter int SYNC_STAGES       = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push_button,
  input  logic infravermelho,
  output logic botao_db,
  output logic pulso_curto,
  output logic pulso_longo,
  output logic ir_sinc,
  output logic ir_borda
);
  localparam int DW = $clog2(DEBOUNCE_P + 1);
  localparam int HW = $clog2(SWITCH_MODE_MIN_T + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(SWITCH_MODE_MIN_T);
  // The cycle that leaves the idle/origin state already counts as one stable sample.
  localparam logic [DW-1:0] DEB_LAST = DW'((DEBOUNCE_P > 1) ? DEBOUNCE_P - 2 : 0);

  typedef enum logic [2:0] {
    SOLTO, CONF_PRESS, PRESSIONADO, LONGO, CONF_SOLTO
  } estado_t;

  logic [SYNC_STAGES-1:0] pb_sync_q, ir_sync_q;
  logic                   b_s;
  estado_t                estado_q;
  logic [DW-1:0]          deb_cnt_q;
  logic [HW-1:0]          hold_cnt_q, hold_cnt_d;
  logic                   origem_longo_q;
  logic                   deb_done;
  logic                   botao_db_q, pulso_curto_q, pulso_longo_q;
  logic                   ir_ant_q, ir_borda_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pb_sync_q <= '0;
      ir_sync_q <= '0;
    end else begin
      pb_sync_q <= {pb_sync_q[SYNC_STAGES-2:0], push_button};
      ir_sync_q <= {ir_sync_q[SYNC_STAGES-2:0], infravermelho};
    end
  end

  assign b_s        = pb_sync_q[SYNC_STAGES-1];
  assign deb_done   = (deb_cnt_q >= DEB_LAST);
  assign hold_cnt_d = hold_cnt_q + HW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado_q       <= SOLTO;
      deb_cnt_q      <= '0;
      hold_cnt_q     <= '0;
      origem_longo_q <= 1'b0;
      botao_db_q     <= 1'b0;
      pulso_curto_q  <= 1'b0;
      pulso_longo_q  <= 1'b0;
    end else begin
      pulso_curto_q <= 1'b0;
      pulso_longo_q <= 1'b0;
      case (estado_q)
        SOLTO: begin
          if (b_s) begin
            estado_q  <= CONF_PRESS;
            deb_cnt_q <= '0;
          end
        end
        CONF_PRESS: begin
          if (!b_s) begin
            estado_q <= SOLTO;
          end else if (deb_done) begin
            estado_q   <= PRESSIONADO;
            botao_db_q <= 1'b1;
            hold_cnt_q <= '0;
          end else begin
            deb_cnt_q <= deb_cnt_q + DW'(1);
          end
        end
        PRESSIONADO: begin
          hold_cnt_q <= hold_cnt_d;
          // Reaching the threshold on the release cycle still counts as a long press.
          if (hold_cnt_d == HOLD_MAX) begin
            pulso_longo_q  <= 1'b1;
            origem_longo_q <= 1'b1;
            estado_q       <= b_s ? LONGO : CONF_SOLTO;
            if (!b_s) deb_cnt_q <= '0;
          end else if (!b_s) begin
            estado_q       <= CONF_SOLTO;
            origem_longo_q <= 1'b0;
            deb_cnt_q      <= '0;
          end
        end
        LONGO: begin
          if (!b_s) begin
            estado_q       <= CONF_SOLTO;
            origem_longo_q <= 1'b1;
            deb_cnt_q      <= '0;
          end
        end
        CONF_SOLTO: begin
          if (b_s) begin
            estado_q <= origem_longo_q ? LONGO : PRESSIONADO;
          end else if (deb_done) begin
            estado_q      <= SOLTO;
            botao_db_q    <= 1'b0;
            pulso_curto_q <= ~origem_longo_q;
          end else begin
            deb_cnt_q <= deb_cnt_q + DW'(1);
          end
        end
        default: estado_q <= SOLTO;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir_ant_q   <= 1'b0;
      ir_borda_q <= 1'b0;
    end else begin
      ir_ant_q   <= ir_sync_q[SYNC_STAGES-1];
      ir_borda_q <= ir_sync_q[SYNC_STAGES-1] & ~ir_ant_q;
    end
  end

  assign botao_db    = botao_db_q;
  assign pulso_curto = pulso_curto_q;
  assign pulso_longo = pulso_longo_q;
  assign ir_sinc     = ir_sync_q[SYNC_STAGES-1];
  assign ir_borda    = ir_borda_q;

endmodule

// File: tb/tb_condicionador_entradas.sv
// Bench for condicionador_entradas: directed boundary presses plus random button segments
// and random IR toggling, compared every cycle against a run-length reference model.
module tb_condicionador_entradas;
  localparam int P = 300;
  localparam int T = 5000;
  localparam int S = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic push_button = 1'b0;
  logic infravermelho = 1'b0;
  logic botao_db, pulso_curto, pulso_longo, ir_sinc, ir_borda;

  condicionador_entradas #(
    .DEBOUNCE_P(P), .SWITCH_MODE_MIN_T(T), .SYNC_STAGES(S)
  ) dut (
    .clk(clk), .rst(rst), .push_button(push_button), .infravermelho(infravermelho),
    .botao_db(botao_db), .pulso_curto(pulso_curto), .pulso_longo(pulso_longo),
    .ir_sinc(ir_sinc), .ir_borda(ir_borda)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Reference model: pins are delayed through S samples, the button level flips once the
  // sampled level has run unchanged for P samples, and held-press samples are tallied.
  logic [S-1:0] m_pb, m_ir;
  logic m_last, m_irant, m_lvl, m_db, m_long_done, e_curto, e_longo, e_borda;
  int   m_run, m_hold;

  task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s @%0t got=%b exp=%b (db,curto,longo,irs,borda)", tag, $time, got, exp);
    end
  endtask

  task automatic mstep();
    logic bs, irs;
    if (!rst) begin
      m_pb = '0; m_ir = '0; m_last = 0; m_irant = 0; m_lvl = 0; m_db = 0;
      m_long_done = 0; e_curto = 0; e_longo = 0; e_borda = 0; m_run = 0; m_hold = 0;
    end else begin
      bs = m_pb[S-1];
      irs = m_ir[S-1];
      m_pb = {m_pb[S-2:0], push_button};
      m_ir = {m_ir[S-2:0], infravermelho};
      e_borda = irs & ~m_irant;
      m_irant = irs;
      e_curto = 0;
      e_longo = 0;
      if (bs == m_lvl) m_run++;
      else begin
        m_lvl = bs;
        m_run = 1;
      end
      if (m_db && m_last && !m_long_done) begin
        m_hold++;
        if (m_hold == T) begin
          e_longo = 1;
          m_long_done = 1;
        end
      end
      if (!m_db && m_lvl && m_run >= P) begin
        m_db = 1;
        m_hold = 0;
        m_long_done = 0;
      end else if (m_db && !m_lvl && m_run >= P) begin
        m_db = 0;
        e_curto = ~m_long_done;
      end
      m_last = bs;
    end
  endtask

  task automatic cyc(input int n, input bit ir_rand = 1'b1);
    repeat (n) begin
      @(posedge clk);
      mstep();
      @(negedge clk);
      chk("outs", {botao_db, pulso_curto, pulso_longo, ir_sinc, ir_borda},
                  {m_db, e_curto, e_longo, m_ir[S-1], e_borda});
      chk("excl", {4'b0, pulso_curto & pulso_longo}, 5'b0);
      if (ir_rand && $urandom_range(63) == 0) infravermelho = ~infravermelho;
    end
  endtask

  task automatic press(input int hi, input int lo);
    push_button = 1'b1;
    cyc(hi);
    push_button = 1'b0;
    cyc(lo);
  endtask

  initial begin
    mstep();
    #1 chk("reset", {botao_db, pulso_curto, pulso_longo, ir_sinc, ir_borda}, 5'b0);
    cyc(4);
    rst = 1'b1;
    cyc(20);

    press(100, 400);              // glitch shorter than debounce
    press(P - 1, 400);            // one sample short of acceptance
    press(P, 400);                // exactly accepted
    press(1000, 400);             // short press
    press(6000, 400);             // long press
    press(P + T - 2, 400);        // released one sample before the long threshold
    press(P + T - 1, 400);        // release coincides with the long threshold

    // Release bounce during an accepted press must not end it.
    push_button = 1'b1; cyc(800);
    push_button = 1'b0; cyc(50);
    push_button = 1'b1; cyc(1500);
    push_button = 1'b0; cyc(400);

    // IR edge with the pin held steady.
    infravermelho = 1'b0; cyc(10, 1'b0);
    infravermelho = 1'b1; cyc(30, 1'b0);
    infravermelho = 1'b0; cyc(10, 1'b0);

    // Reset in the middle of an accepted press, button and IR held through release.
    push_button = 1'b1; infravermelho = 1'b1;
    cyc(1000, 1'b0);
    rst = 1'b0;
    #1 chk("rst_async", {botao_db, pulso_curto, pulso_longo, ir_sinc, ir_borda}, 5'b0);
    cyc(3, 1'b0);
    rst = 1'b1;
    cyc(600, 1'b0);
    push_button = 1'b0;
    cyc(400);

    for (int i = 0; i < 25; i++) begin
      int len;
      case ($urandom_range(3))
        0:       len = $urandom_range(40, 1);
        1:       len = $urandom_range(350, 250);
        2:       len = $urandom_range(2000, 400);
        default: len = $urandom_range(5400, 4900);
      endcase
      push_button = ~push_button;
      cyc(len);
    end
    push_button = 1'b0;
    cyc(400);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
